// File: rtl/cpu_types_pkg.sv
// Shared types for the data-side cache responder.
// Provides the word type, the cache geometry constants, the controller
// state encoding, the per-set frame layout and the address-split view.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int DINDEX_W = 4;
  localparam int DTAG_W   = 32 - DINDEX_W - 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WB       = 3'd1,
    FILL     = 3'd2,
    FLUSH    = 3'd3,
    FLUSH_WB = 3'd4,
    DONE     = 3'd5
  } dcache_state_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [DTAG_W-1:0] tag;
    word_t             data;
  } dcache_frame_t;

  typedef struct packed {
    logic [DTAG_W-1:0]   tag;
    logic [DINDEX_W-1:0] idx;
    logic [1:0]          bytoff;
  } dcacheaddr_t;

  // Rebuild the word-aligned memory address of a block from its tag and set.
  function automatic word_t frame_addr(input logic [DTAG_W-1:0] tag,
                                       input logic [DINDEX_W-1:0] idx);
    dcacheaddr_t a;
    a.tag    = tag;
    a.idx    = idx;
    a.bytoff = 2'b00;
    return word_t'(a);
  endfunction

endpackage

// File: rtl/dcache_flush_ctr.sv
// Set-index scan counter used while flushing dirty blocks on halt.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : return the counter to set 0 (has priority over en_i)
//   en_i          : advance to the next set
//   idx_o         : set currently being examined
//   wrap_o        : counter sits on the last set, so advancing now wraps
module dcache_flush_ctr #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] idx_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, advance or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign idx_o  = cnt_q;
  // Deliberately independent of en_i so the controller can use it in the
  // same combinational block that drives en_i.
  assign wrap_o = (cnt_q == {W{1'b1}});

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, one-word-per-block data cache between the MEM
// stage and the memory controller. Hits answer in the same cycle; misses
// write back a dirty victim, refill, and hit on the following cycle. On halt
// every dirty block is written back in set order, then flushed rises.
// Ports:
//   CLK, nRST                 : clock, asynchronous active-low reset
//   dmemREN/dmemWEN/dmemaddr/dmemstore : MEM-stage request (held while !dhit)
//   halt                      : start flushing
//   dhit, dmemload            : request satisfied / load data
//   flushed                   : flush complete, sticky until reset
//   dREN/dWEN/daddr/dstore    : memory-side request (zero when idle)
//   dwait, dload              : memory busy / memory read data
// INDEX_W must equal DINDEX_W since the frame layout comes from the package.
module dcache_responder
  import cpu_types_pkg::*;
#(
  parameter int INDEX_W = DINDEX_W,
  parameter int TAG_W   = 32 - INDEX_W - 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int NSETS = 2 ** INDEX_W;

  dcache_frame_t frames_q [NSETS];
  dcache_state_t state_q, state_d;

  logic [TAG_W-1:0]   req_tag_s;
  logic [INDEX_W-1:0] req_idx_s;
  logic [INDEX_W-1:0] flush_idx_s;
  dcache_frame_t      frame_s;
  dcache_frame_t      flush_frame_s;
  logic               req_s, hit_s;
  logic               wr_hit_s, wb_done_s, fill_done_s, flush_wb_done_s;
  logic               ctr_clr_s, ctr_en_s, ctr_wrap_s;
  logic               unused_bytoff_s;

  assign req_tag_s       = dmemaddr[31:2+INDEX_W];
  assign req_idx_s       = dmemaddr[1+INDEX_W:2];
  assign unused_bytoff_s = ^dmemaddr[1:0];
  assign frame_s         = frames_q[req_idx_s];
  assign flush_frame_s   = frames_q[flush_idx_s];
  assign req_s           = dmemREN | dmemWEN;
  assign hit_s           = req_s && frame_s.valid && (frame_s.tag == req_tag_s);
  assign flushed         = (state_q == DONE);

  dcache_flush_ctr #(.W(INDEX_W)) u_flush_ctr (
    .clk_i  (CLK),
    .rst_ni (nRST),
    .clr_i  (ctr_clr_s),
    .en_i   (ctr_en_s),
    .idx_o  (flush_idx_s),
    .wrap_o (ctr_wrap_s)
  );

  // Controller next state, hit/load response and memory-side request.
  always_comb begin
    state_d         = state_q;
    dhit            = 1'b0;
    dmemload        = 32'h0000_0000;
    dREN            = 1'b0;
    dWEN            = 1'b0;
    daddr           = 32'h0000_0000;
    dstore          = 32'h0000_0000;
    wr_hit_s        = 1'b0;
    wb_done_s       = 1'b0;
    fill_done_s     = 1'b0;
    flush_wb_done_s = 1'b0;
    ctr_clr_s       = 1'b0;
    ctr_en_s        = 1'b0;
    case (state_q)
      IDLE: begin
        ctr_clr_s = 1'b1;
        if (hit_s) begin
          dhit = 1'b1;
          // Write wins when both request lines are up.
          if (dmemWEN) begin
            wr_hit_s = 1'b1;
          end else begin
            dmemload = frame_s.data;
          end
        end else begin
          dhit = 1'b0;
        end
        // A hit in the halt cycle is still serviced above.
        if (halt) begin
          state_d = FLUSH;
        end else if (req_s && !hit_s) begin
          if (frame_s.dirty) begin
            state_d = WB;
          end else begin
            state_d = FILL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WB: begin
        dWEN   = 1'b1;
        daddr  = frame_addr(frame_s.tag, req_idx_s);
        dstore = frame_s.data;
        if (!dwait) begin
          wb_done_s = 1'b1;
          state_d   = FILL;
        end else begin
          state_d = WB;
        end
      end
      FILL: begin
        dREN  = 1'b1;
        daddr = {dmemaddr[31:2], 2'b00};
        if (!dwait) begin
          fill_done_s = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = FILL;
        end
      end
      FLUSH: begin
        if (flush_frame_s.dirty) begin
          state_d = FLUSH_WB;
        end else begin
          ctr_en_s = 1'b1;
          state_d  = ctr_wrap_s ? DONE : FLUSH;
        end
      end
      FLUSH_WB: begin
        dWEN   = 1'b1;
        daddr  = frame_addr(flush_frame_s.tag, flush_idx_s);
        dstore = flush_frame_s.data;
        if (!dwait) begin
          flush_wb_done_s = 1'b1;
          ctr_en_s        = 1'b1;
          state_d         = ctr_wrap_s ? DONE : FLUSH;
        end else begin
          state_d = FLUSH_WB;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame storage: write hits, victim write-back, refill and flush clears.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NSETS; i++) begin
        frames_q[i] <= '0;
      end
    end else begin
      if (wr_hit_s) begin
        frames_q[req_idx_s].data  <= dmemstore;
        frames_q[req_idx_s].dirty <= 1'b1;
      end
      if (wb_done_s) begin
        frames_q[req_idx_s].dirty <= 1'b0;
      end
      if (fill_done_s) begin
        frames_q[req_idx_s] <= '{valid: 1'b1, dirty: 1'b0, tag: req_tag_s, data: dload};
      end
      if (flush_wb_done_s) begin
        frames_q[flush_idx_s].dirty <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
module tb_dcache_responder;

  logic        CLK = 1'b0;
  logic        nRST, dmemREN, dmemWEN, halt, dwait;
  logic [31:0] dmemaddr, dmemstore, dload;
  logic        dhit, flushed, dREN, dWEN;
  logic [31:0] dmemload, daddr, dstore;

  dcache_responder dut (
    .CLK(CLK), .nRST(nRST), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .halt(halt),
    .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: cache contents per set and a sparse backing memory.
  logic        m_valid [16];
  logic        m_dirty [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Expected outputs for the current cycle.
  logic        exp_en = 1'b0, flush_mode = 1'b0;
  logic        exp_dhit, exp_dren, exp_dwen, exp_flushed, exp_load_chk;
  logic [31:0] exp_load, exp_daddr, exp_dstore;
  logic [31:0] fq_addr[$], fq_data[$];
  logic [31:0] seen_fill_addr, seen_wb_addr, seen_wb_data, seen_load;
  int          dhit_pulses = 0;
  int          force_lat = -1;

  // Single compare point, on the falling edge.
  always @(negedge CLK) begin
    if (exp_en) begin
      if (!flush_mode) begin
        check("dhit", dhit, exp_dhit);
        check("dREN", dREN, exp_dren);
        check("dWEN", dWEN, exp_dwen);
        check("daddr", daddr, exp_daddr);
        check("dstore", dstore, exp_dstore);
        check("flushed", flushed, exp_flushed);
        if (exp_load_chk) check("dmemload", dmemload, exp_load);
      end else begin
        check("flush_dhit", dhit, 1'b0);
        check("flush_dREN", dREN, 1'b0);
        if (dWEN) begin
          check("flush_wb_addr", daddr, (fq_addr.size() != 0) ? fq_addr[0] : 32'hFFFF_FFFF);
          check("flush_wb_data", dstore, (fq_data.size() != 0) ? fq_data[0] : ~dstore);
        end else begin
          check("flush_idle_daddr", daddr, 32'h0);
          check("flush_idle_dstore", dstore, 32'h0);
        end
        check("flush_flushed_early", flushed && (fq_addr.size() != 0), 1'b0);
      end
    end
    if (nRST) begin
      if (dWEN) begin seen_wb_addr = daddr; seen_wb_data = dstore; end
      if (dREN) seen_fill_addr = daddr;
      if (dhit) begin
        dhit_pulses++;
        if (dmemREN && !dmemWEN) seen_load = dmemload;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_exp_idle();
    exp_dhit = 1'b0; exp_dren = 1'b0; exp_dwen = 1'b0; exp_flushed = 1'b0;
    exp_daddr = 32'h0; exp_dstore = 32'h0; exp_load_chk = 1'b0; exp_load = 32'h0;
  endtask

  task automatic do_reset();
    exp_en = 1'b0; flush_mode = 1'b0;
    nRST = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; halt = 1'b0; dwait = 1'b0;
    dmemaddr = 32'h0; dmemstore = 32'h0; dload = 32'h0;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    step(); step();
    nRST = 1'b1;
  endtask

  // One memory transfer as the memory controller sees it.
  task automatic mem_xfer(input bit is_wr, input logic [31:0] a, input logic [31:0] d);
    int lat;
    lat = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
    for (int k = 0; k <= lat; k++) begin
      set_exp_idle();
      exp_dren = !is_wr; exp_dwen = is_wr; exp_daddr = a; exp_dstore = is_wr ? d : 32'h0;
      dwait = (k < lat);
      dload = (!is_wr && k == lat) ? mem_rd(a) : $urandom;
      step();
    end
  endtask

  task automatic do_req(input bit ren, input bit wen, input logic [31:0] a,
                        input logic [31:0] d, input bit halt_mid);
    logic [3:0]  idx;
    logic [25:0] tag;
    logic [31:0] wa, va;
    idx = a[5:2]; tag = a[31:6]; wa = {a[31:2], 2'b00};
    dmemREN = ren; dmemWEN = wen; dmemaddr = a; dmemstore = d;
    exp_en = 1'b1;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      set_exp_idle();
      dwait = 1'($urandom_range(0, 1));
      step();
      if (halt_mid) halt = 1'b1;
      if (m_valid[idx] && m_dirty[idx]) begin
        va = {m_tag[idx], idx, 2'b00};
        mem_xfer(1'b1, va, m_data[idx]);
        mem[va] = m_data[idx];
        m_dirty[idx] = 1'b0;
      end
      mem_xfer(1'b0, wa, 32'h0);
      m_valid[idx] = 1'b1; m_tag[idx] = tag; m_data[idx] = mem_rd(wa); m_dirty[idx] = 1'b0;
    end
    set_exp_idle();
    exp_dhit = 1'b1;
    if (ren && !wen) begin exp_load_chk = 1'b1; exp_load = m_data[idx]; end
    dwait = 1'($urandom_range(0, 1));
    step();
    if (wen) begin m_data[idx] = d; m_dirty[idx] = 1'b1; end
    dmemREN = 1'b0; dmemWEN = 1'b0;
    set_exp_idle();
  endtask

  task automatic do_flush(output int bursts);
    int nexp, lat, cyc;
    bit completing;
    logic [31:0] fa;
    fq_addr.delete(); fq_data.delete();
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        fq_addr.push_back({m_tag[i], 4'(i), 2'b00});
        fq_data.push_back(m_data[i]);
      end
    end
    nexp = fq_addr.size();
    bursts = 0; cyc = 0;
    lat = int'($urandom_range(0, 3));
    halt = 1'b1; exp_en = 1'b1; flush_mode = 1'b1;
    while (!flushed && cyc < 300) begin
      completing = 1'b0;
      if (dWEN) begin
        if (lat == 0) begin dwait = 1'b0; completing = 1'b1; end
        else begin dwait = 1'b1; lat--; end
      end else begin
        dwait = 1'($urandom_range(0, 1));
      end
      step();
      if (completing && fq_addr.size() != 0) begin
        fa = fq_addr.pop_front();
        mem[fa] = fq_data.pop_front();
        m_dirty[fa[5:2]] = 1'b0;
        bursts++;
        lat = int'($urandom_range(0, 3));
      end
      cyc++;
    end
    flush_mode = 1'b0;
    check("flush_reached", flushed, 1'b1);
    check("flush_bursts", bursts, nexp);
    // DONE must hold with no hits and no traffic, even with a request up.
    for (int k = 0; k < 5; k++) begin
      set_exp_idle(); exp_flushed = 1'b1;
      dmemREN = k[0]; dmemWEN = k[1]; dmemaddr = {$urandom} & 32'h0000_00FC;
      dwait = 1'($urandom_range(0, 1));
      step();
    end
    dmemREN = 1'b0; dmemWEN = 1'b0;
    exp_en = 1'b0;
  endtask

  initial begin
    int nb, p0, op;
    logic [31:0] a;

    // Reset state.
    do_reset();
    exp_en = 1'b1; set_exp_idle(); exp_load_chk = 1'b1;
    step();

    // Cold read miss, two wait cycles.
    mem[32'h104] = 32'hDEAD_BEEF;
    force_lat = 2;
    p0 = dhit_pulses;
    do_req(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0);
    check("cold_fill_addr", seen_fill_addr, 32'h0000_0104);
    check("cold_load", seen_load, 32'hDEAD_BEEF);
    check("cold_dhit_once", dhit_pulses - p0, 32'd1);
    force_lat = -1;

    // Write hit then read hit.
    do_req(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 1'b0);
    do_req(1'b1, 1'b0, 32'h0000_0104, 32'h0, 1'b0);
    check("wr_rd_hit_load", seen_load, 32'h1234_5678);

    // Conflict with dirty victim.
    do_req(1'b1, 1'b0, 32'h0000_0144, 32'h0, 1'b0);
    check("victim_wb_addr", seen_wb_addr, 32'h0000_0104);
    check("victim_wb_data", seen_wb_data, 32'h1234_5678);
    check("victim_fill_addr", seen_fill_addr, 32'h0000_0144);

    // Flush with dirty sets 0, 3, 15.
    do_reset();
    do_req(1'b0, 1'b1, 32'h0000_0000, 32'hA000_0000, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_100C, 32'hA000_0003, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_003C, 32'hA000_000F, 1'b0);
    do_flush(nb);
    check("flush_three_bursts", nb, 32'd3);
    check("flush_last_addr", seen_wb_addr, 32'h0000_003C);

    // Reset mid-fill.
    do_reset();
    exp_en = 1'b1; set_exp_idle();
    dmemREN = 1'b1; dmemaddr = 32'h0000_0208;
    step();
    exp_dren = 1'b1; exp_daddr = 32'h0000_0208; dwait = 1'b1;
    step();
    #2;
    exp_en = 1'b0;
    nRST = 1'b0;
    #1;
    check("rst_mid_dREN", dREN, 1'b0);
    check("rst_mid_daddr", daddr, 32'h0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
    seen_fill_addr = 32'h0;
    do_req(1'b1, 1'b0, 32'h0000_0208, 32'h0, 1'b0);
    check("rst_refill_addr", seen_fill_addr, 32'h0000_0208);

    // Halt during a miss with a dirty victim.
    do_reset();
    do_req(1'b0, 1'b1, 32'h0000_001C, 32'h7777_0007, 1'b0);
    do_req(1'b0, 1'b1, 32'h0000_0104, 32'h5555_0001, 1'b0);
    p0 = dhit_pulses;
    do_req(1'b1, 1'b0, 32'h0000_0144, 32'h0, 1'b1);
    check("halt_miss_dhit_once", dhit_pulses - p0, 32'd1);
    do_flush(nb);
    check("halt_miss_bursts", nb, 32'd1);
    check("halt_miss_dhit_none", dhit_pulses - p0, 32'd1);

    // Randomized traffic against the model, finished by a flush.
    do_reset();
    for (int n = 0; n < 250; n++) begin
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      a[31:8] = 24'($urandom_range(0, 1)) << 12;
      op = int'($urandom_range(0, 7));
      if (op < 4)       do_req(1'b1, 1'b0, a, 32'h0, 1'b0);
      else if (op < 7)  do_req(1'b0, 1'b1, a, $urandom, 1'b0);
      else              do_req(1'b1, 1'b1, a, $urandom, 1'b0);
    end
    do_flush(nb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
